gray_fifo_ctrl: RTL and testbench
=================================

# gray_fifo_ctrl

Single-clock FIFO control block that sequences a pair of Gray-coded pointer counters (write and read) for an external dual-port RAM. It accepts write/read requests, issues RAM enables and binary addresses, and derives full/empty/almost flags, occupancy and sticky error bits from the Gray pointers. It sits between requesting logic and the storage array. Its Gray pointers are exported so a later dual-clock variant can reuse the same interface.

## Interface
- ADDR_W, 4, RAM address width; depth = 2^ADDR_W
- AF_LEVEL, 14, almost_full asserted when count >= AF_LEVEL
- AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- clear  input  1  synchronous flush: pointers, count and error bits return to reset values
- wr_req  input  1  write request
- rd_req  input  1  read request
- wr_en  output  1  write accepted this cycle (RAM write enable)
- rd_en  output  1  read accepted this cycle (RAM read enable)
- wr_addr  output  ADDR_W  binary RAM write address
- rd_addr  output  ADDR_W  binary RAM read address
- wr_ptr_gray  output  ADDR_W+1  registered Gray write pointer
- rd_ptr_gray  output  ADDR_W+1  registered Gray read pointer
- count  output  ADDR_W+1  occupancy, 0..2^ADDR_W
- full, empty, almost_full, almost_empty  output  1 each  status flags
- overflow, underflow  output  1 each  sticky error bits

## Operation
- Pointers are (ADDR_W+1)-bit binary counters, wb and rb, held in registers. Gray outputs are registered as bin ^ (bin >> 1) and are updated in the same edge as the binary counters.
- wr_addr = wb[ADDR_W-1:0] and rd_addr = rb[ADDR_W-1:0].
- empty = (wr_ptr_gray == rd_ptr_gray).
- full = (wr_ptr_gray == {~rd_ptr_gray[ADDR_W:ADDR_W-1], rd_ptr_gray[ADDR_W-2:0]}). Flags are computed from the Gray pointers, not from count.
- count = (wb - rb) mod 2^(ADDR_W+1).
- wr_en = wr_req & ~full & ~clear. rd_en = rd_req & ~empty & ~clear. Both are combinational from current state.
- Simultaneous requests:
  - When full, only the read is accepted.
  - When empty, only the write is accepted.
  - Otherwise both are accepted and count is unchanged.
- overflow sets on any cycle with wr_req & full. underflow sets on any cycle with rd_req & empty. Both stay set until rst or clear.
- Pointers wrap from 2^(ADDR_W+1)-1 to 0. The Gray pointer changes exactly one bit per accepted operation, including across the wrap.
- clear has priority over requests. On the clear edge no operation is accepted and all state returns to reset values.

## Timing
- Reset values (asynchronous, immediate):
  - wb = rb = 0, all Gray outputs 0, addresses 0, count 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - overflow = underflow = 0, wr_en = rd_en = 0 (requests low).
- Accepting edge: a request accepted while wr_en/rd_en is high advances its pointer on that rising edge. Flags and count reflect the new pointers from the following cycle; they are combinational from registers.
- RAM write data is written at wr_addr on the wr_en edge. Read data is valid one cycle after rd_en (RAM latency; not this block's concern).
- Back-to-back operations are allowed every cycle. Throughput is one write plus one read per cycle.
- Reset asserted mid-operation: all state is cleared immediately. Accepted operations in flight are discarded.
- Error bits set on the edge following the offending request and are visible from the next cycle.

## Test plan
- Reset: hold rst 2 cycles. Required: count=0, empty=1, full=0, both Gray pointers 00000, overflow=underflow=0.
- Fill: 16 consecutive wr_req with ADDR_W=4. Required: full=1 and count=16 after the 16th edge, wr_ptr_gray=11000, almost_full first high at count=14. A 17th wr_req gives wr_en=0 and overflow=1 on the next cycle, with wr_ptr_gray unchanged.
- Drain: 16 rd_req after fill. Required: empty=1, rd_ptr_gray=11000, count=0. A 17th rd_req gives rd_en=0 and underflow=1.
- Wrap and Gray property: 40 interleaved write/read pairs, so both pointers pass 31 to 0 (Gray 10000 to 00000). Required: each pointer changes by Hamming distance <= 1 every cycle and count stays consistent.
- Simultaneous requests:
  - Full with both requests: rd_en=1, wr_en=0, count becomes 15.
  - Empty with both requests: wr_en=1, rd_en=0, count becomes 1.
  - Count=5 with both requests: both accepted, count stays 5.
- Flush and reset mid-operation:
  - clear at count=7 with wr_req high: no write accepted, count=0, empty=1, error bits cleared on the next cycle.
  - rst pulsed mid-burst: outputs at reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/gray_fifo_ctrl.sv
// Single-clock FIFO pointer controller: binary/Gray write and read pointers,
// RAM enables and addresses, occupancy, status flags and sticky error bits.
module gray_fifo_ctrl #(
   parameter int ADDR_W   = 4,
   parameter int AF_LEVEL = 14,
   parameter int AE_LEVEL = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              wr_req,
   input  logic              rd_req,
   output logic              wr_en,
   output logic              rd_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [ADDR_W:0]   wr_ptr_gray,
   output logic [ADDR_W:0]   rd_ptr_gray,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic              overflow,
   output logic              underflow
);

   localparam int PW = ADDR_W + 1;

   logic [PW-1:0] wb_q, wb_d, rb_q, rb_d;
   logic [PW-1:0] wg_q, wg_d, rg_q, rg_d;
   logic          ovf_q, ovf_d, unf_q, unf_d;

   // Full compares Gray pointers: top two bits inverted, remaining bits equal.
   assign empty = (wg_q == rg_q);
   assign full  = (wg_q == {~rg_q[ADDR_W:ADDR_W-1], rg_q[ADDR_W-2:0]});

   assign count        = wb_q - rb_q;
   assign almost_full  = (count >= PW'(AF_LEVEL));
   assign almost_empty = (count <= PW'(AE_LEVEL));

   assign wr_en = wr_req & ~full & ~clear;
   assign rd_en = rd_req & ~empty & ~clear;

   assign wr_addr     = wb_q[ADDR_W-1:0];
   assign rd_addr     = rb_q[ADDR_W-1:0];
   assign wr_ptr_gray = wg_q;
   assign rd_ptr_gray = rg_q;
   assign overflow    = ovf_q;
   assign underflow   = unf_q;

   always_comb begin
      wb_d  = wb_q + {{(PW-1){1'b0}}, wr_en};
      rb_d  = rb_q + {{(PW-1){1'b0}}, rd_en};
      ovf_d = ovf_q | (wr_req & full);
      unf_d = unf_q | (rd_req & empty);
      if (clear) begin
         wb_d  = '0;
         rb_d  = '0;
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end
      wg_d = wb_d ^ (wb_d >> 1);
      rg_d = rb_d ^ (rb_d >> 1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_q  <= '0;
         rb_q  <= '0;
         wg_q  <= '0;
         rg_q  <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         wb_q  <= wb_d;
         rb_q  <= rb_d;
         wg_q  <= wg_d;
         rg_q  <= rg_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

endmodule

// File: tb/tb_gray_fifo_ctrl.sv
// Directed bench for gray_fifo_ctrl: a counter-based reference model pushes
// the expected post-edge state to a queue that is popped after each edge.
module tb_gray_fifo_ctrl;

   logic       clk = 1'b0;
   logic       rst, clear, wr_req, rd_req;
   logic       wr_en, rd_en;
   logic [3:0] wr_addr, rd_addr;
   logic [4:0] wr_ptr_gray, rd_ptr_gray, count;
   logic       full, empty, almost_full, almost_empty, overflow, underflow;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [4:0] cnt, wg, rg;
      logic       f, e, af, ae, ov, un;
   } exp_t;
   exp_t exp_q[$];

   int         m_wb, m_rb;
   logic       m_ovf, m_unf;
   logic [4:0] prev_wg, prev_rg;

   gray_fifo_ctrl #(.ADDR_W(4), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
      .clk(clk), .rst(rst), .clear(clear), .wr_req(wr_req), .rd_req(rd_req),
      .wr_en(wr_en), .rd_en(rd_en), .wr_addr(wr_addr), .rd_addr(rd_addr),
      .wr_ptr_gray(wr_ptr_gray), .rd_ptr_gray(rd_ptr_gray), .count(count),
      .full(full), .empty(empty), .almost_full(almost_full),
      .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [4:0] to_gray(input int b);
      logic [4:0] v;
      v = b[4:0];
      return v ^ (v >> 1);
   endfunction

   task automatic model_reset();
      m_wb = 0; m_rb = 0; m_ovf = 1'b0; m_unf = 1'b0;
      prev_wg = '0; prev_rg = '0;
      exp_q.delete();
   endtask

   task automatic step(input logic wr, input logic rd, input logic clr);
      int   occ;
      logic m_full, m_empty, e_wen, e_ren;
      exp_t e;
      exp_t got;
      @(negedge clk);
      wr_req = wr; rd_req = rd; clear = clr;
      #1;
      occ     = (m_wb - m_rb) & 31;
      m_full  = (occ == 16);
      m_empty = (occ == 0);
      e_wen   = wr && !m_full && !clr;
      e_ren   = rd && !m_empty && !clr;
      chk("wr_en", wr_en, e_wen);
      chk("rd_en", rd_en, e_ren);
      chk("wr_addr", wr_addr, m_wb & 15);
      chk("rd_addr", rd_addr, m_rb & 15);
      if (clr) begin
         m_wb = 0; m_rb = 0; m_ovf = 1'b0; m_unf = 1'b0;
      end else begin
         if (wr && m_full)  m_ovf = 1'b1;
         if (rd && m_empty) m_unf = 1'b1;
         m_wb = (m_wb + int'(e_wen)) & 31;
         m_rb = (m_rb + int'(e_ren)) & 31;
      end
      occ   = (m_wb - m_rb) & 31;
      e.cnt = occ[4:0];
      e.wg  = to_gray(m_wb);
      e.rg  = to_gray(m_rb);
      e.f   = (occ == 16);
      e.e   = (occ == 0);
      e.af  = (occ >= 14);
      e.ae  = (occ <= 2);
      e.ov  = m_ovf;
      e.un  = m_unf;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      got = exp_q.pop_front();
      chk("count", count, got.cnt);
      chk("wr_ptr_gray", wr_ptr_gray, got.wg);
      chk("rd_ptr_gray", rd_ptr_gray, got.rg);
      chk("full", full, got.f);
      chk("empty", empty, got.e);
      chk("almost_full", almost_full, got.af);
      chk("almost_empty", almost_empty, got.ae);
      chk("overflow", overflow, got.ov);
      chk("underflow", underflow, got.un);
      if (!clr) begin
         chk("wg_hamming", ($countones(wr_ptr_gray ^ prev_wg) <= 1), 1);
         chk("rg_hamming", ($countones(rd_ptr_gray ^ prev_rg) <= 1), 1);
      end
      prev_wg = wr_ptr_gray;
      prev_rg = rd_ptr_gray;
      $display("t=%0t wr=%0b rd=%0b clr=%0b wr_en=%0b rd_en=%0b count=%0d wg=%05b rg=%05b f=%0b e=%0b ovf=%0b unf=%0b",
               $time, wr, rd, clr, e_wen, e_ren, count, wr_ptr_gray, rd_ptr_gray,
               full, empty, overflow, underflow);
   endtask

   task automatic check_reset_state(input string pfx);
      chk({pfx, "_count"}, count, 0);
      chk({pfx, "_empty"}, empty, 1);
      chk({pfx, "_full"}, full, 0);
      chk({pfx, "_almost_empty"}, almost_empty, 1);
      chk({pfx, "_almost_full"}, almost_full, 0);
      chk({pfx, "_wg"}, wr_ptr_gray, 0);
      chk({pfx, "_rg"}, rd_ptr_gray, 0);
      chk({pfx, "_wr_addr"}, wr_addr, 0);
      chk({pfx, "_rd_addr"}, rd_addr, 0);
      chk({pfx, "_overflow"}, overflow, 0);
      chk({pfx, "_underflow"}, underflow, 0);
      chk({pfx, "_wr_en"}, wr_en, 0);
      chk({pfx, "_rd_en"}, rd_en, 0);
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_state("reset");
      @(negedge clk);
      rst = 1'b0;

      // Fill to 16, then one write too many.
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0);
      chk("fill_wg_11000", wr_ptr_gray, 5'b11000);
      chk("fill_full", full, 1);
      step(1'b1, 1'b0, 1'b0);
      chk("overflow_wg_held", wr_ptr_gray, 5'b11000);

      // Drain to 0, then one read too many.
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0);
      chk("drain_rg_11000", rd_ptr_gray, 5'b11000);
      step(1'b0, 1'b1, 1'b0);
      chk("underflow_set", underflow, 1);

      // Clear flushes the sticky error bits.
      step(1'b0, 1'b0, 1'b1);

      // Interleaved pairs carry both pointers across the 31 -> 0 wrap.
      for (int i = 0; i < 40; i++) begin
         step(1'b1, 1'b0, 1'b0);
         step(1'b0, 1'b1, 1'b0);
      end

      // Simultaneous requests at full, empty and mid-level.
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      chk("both_at_full_count", count, 15);
      for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      chk("both_at_empty_count", count, 1);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      chk("both_at_5_count", count, 5);

      // Clear at count 7 with a write pending.
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      chk("pre_clear_count", count, 7);
      step(1'b1, 1'b0, 1'b1);

      // Asynchronous reset in the middle of a write burst.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
      #2;
      rst = 1'b1; wr_req = 1'b0;
      #1;
      check_reset_state("async_rst");
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      step(1'b1, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
